// File: rtl/pc_unit.sv
// pc_unit: fetch program-counter unit.
// Produces the fetch address, advances it under the fetch handshake, applies
// trap/redirect targets with fixed priority (trap > redirect > sequential),
// and buffers a target that arrives while paused until the pipeline resumes.
// Optional feature macro: PC_COMPRESSED_EN (16-bit steps, bit-0-only masking).
//
// Handshake: pc_valid_o=1 marks pc_out_o as a live fetch request. A fetch
// happens on a cycle with pc_valid_o=1, fetch_ready_i=1 and pause_i=0; the
// address only advances on such a cycle, and otherwise changes only when a
// trap or redirect is applied.

`ifndef CPU_START_ADDR
`define CPU_START_ADDR '0
`endif

module pc_unit #(
    parameter int                 XLEN       = 32,
    parameter logic [XLEN-1:0]    START_ADDR = `CPU_START_ADDR
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pause_i,
    input  logic            fetch_ready_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            step_half_i,
    output logic [XLEN-1:0] pc_out_o,
    output logic            pc_valid_o,
    output logic            misalign_o,
    output logic            pending_o,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

`ifdef PC_COMPRESSED_EN
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(1);
`else
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(3);
`endif

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] buf_addr_q, buf_addr_d;
    logic            buf_trap_q, buf_trap_d;

    logic [XLEN-1:0] step;
    logic            any_req;
    logic [XLEN-1:0] req_addr;
    logic            load;
    logic [XLEN-1:0] tgt;

`ifdef PC_COMPRESSED_EN
    assign step = step_half_i ? XLEN'(2) : XLEN'(4);
`else
    // step_half_i has no meaning when only 32-bit instructions exist.
    logic unused_step_half;
    assign unused_step_half = step_half_i;
    assign step = XLEN'(4);
`endif

    // Trap wins over redirect whenever both arrive together.
    assign any_req  = trap_valid_i | redirect_valid_i;
    assign req_addr = trap_valid_i ? trap_vec_i : redirect_addr_i;

    // Next-state, next-pc and pending-buffer logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mis_d      = 1'b0;
        buf_addr_d = buf_addr_q;
        buf_trap_d = buf_trap_q;
        load       = 1'b0;
        tgt        = '0;

        case (state_q)
            BOOT, RUN: begin
                if (pause_i) begin
                    state_d = RUN;
                    if (any_req) begin
                        buf_addr_d = req_addr;
                        buf_trap_d = trap_valid_i;
                        state_d    = PEND;
                    end
                end else if (any_req) begin
                    load    = 1'b1;
                    tgt     = req_addr;
                    state_d = RUN;
                end else begin
                    state_d = RUN;
                    // BOOT never advances: its address was not offered for fetch.
                    if (state_q == RUN && fetch_ready_i) begin
                        pc_d = pc_q + step;
                    end
                end
            end
            PEND: begin
                if (pause_i) begin
                    // A buffered trap may only be displaced by another trap.
                    if (trap_valid_i) begin
                        buf_addr_d = trap_vec_i;
                        buf_trap_d = 1'b1;
                    end else if (redirect_valid_i && !buf_trap_q) begin
                        buf_addr_d = redirect_addr_i;
                        buf_trap_d = 1'b0;
                    end
                end else begin
                    load       = 1'b1;
                    tgt        = any_req ? req_addr : buf_addr_q;
                    buf_trap_d = 1'b0;
                    state_d    = RUN;
                end
            end
            default: state_d = BOOT;
        endcase

        if (load) begin
            pc_d  = tgt & ~LOW_MASK;
            mis_d = |(tgt & LOW_MASK);
        end
    end

    // State, pc, misalign flag and pending buffer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= BOOT;
            pc_q       <= START_ADDR;
            mis_q      <= 1'b0;
            buf_addr_q <= '0;
            buf_trap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mis_q      <= mis_d;
            buf_addr_q <= buf_addr_d;
            buf_trap_q <= buf_trap_d;
        end
    end

    assign pc_out_o    = pc_q;
    assign pc_valid_o  = (state_q == RUN);
    assign pending_o   = (state_q == PEND);
    assign misalign_o  = mis_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed vectors with literal expectations plus a
// behavioural model compared against the DUT every cycle.
`timescale 1ns/1ps

module tb_pc_unit;

    localparam int              XLEN  = 32;
    localparam logic [XLEN-1:0] START = 32'h0000_0100;

`ifdef PC_COMPRESSED_EN
    localparam logic [XLEN-1:0] MASK = 32'h1;
`else
    localparam logic [XLEN-1:0] MASK = 32'h3;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, pause, fetch_ready, redirect_valid, trap_valid, step_half;
    logic [XLEN-1:0] redirect_addr, trap_vec;
    logic [XLEN-1:0] pc_out;
    logic            pc_valid, misalign, pending;
    logic [1:0]      dbg_state;

    pc_unit #(.XLEN(XLEN), .START_ADDR(START)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .pause_i          (pause),
        .fetch_ready_i    (fetch_ready),
        .redirect_valid_i (redirect_valid),
        .redirect_addr_i  (redirect_addr),
        .trap_valid_i     (trap_valid),
        .trap_vec_i       (trap_vec),
        .step_half_i      (step_half),
        .pc_out_o         (pc_out),
        .pc_valid_o       (pc_valid),
        .misalign_o       (misalign),
        .pending_o        (pending),
        .dbg_state_o      (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // behavioural model: what the fetch address and flags must be
    logic [XLEN-1:0] m_pc;
    logic            m_valid, m_pend, m_mis, m_btrap;
    logic [XLEN-1:0] m_buf;

    function automatic void m_apply(input logic [XLEN-1:0] t);
        m_pc    = t & ~MASK;
        m_mis   = ((t & MASK) != 0);
        m_valid = 1'b1;
        m_pend  = 1'b0;
    endfunction

    function automatic void model_edge();
        logic            req;
        logic [XLEN-1:0] raddr;
        logic [XLEN-1:0] inc;
        req   = trap_valid || redirect_valid;
        raddr = trap_valid ? trap_vec : redirect_addr;
`ifdef PC_COMPRESSED_EN
        inc = step_half ? 32'd2 : 32'd4;
`else
        inc = 32'd4;
`endif
        if (rst) begin
            m_pc = START; m_valid = 0; m_pend = 0; m_mis = 0; m_buf = '0; m_btrap = 0;
        end else if (m_pend) begin
            m_mis = 0;
            if (pause) begin
                if (trap_valid) begin
                    m_buf = trap_vec; m_btrap = 1;
                end else if (redirect_valid && !m_btrap) begin
                    m_buf = redirect_addr; m_btrap = 0;
                end
            end else begin
                m_apply(req ? raddr : m_buf);
                m_btrap = 0;
            end
        end else if (pause) begin
            m_mis = 0;
            if (req) begin
                m_buf = raddr; m_btrap = trap_valid; m_pend = 1; m_valid = 0;
            end else begin
                m_valid = 1;
            end
        end else if (req) begin
            m_apply(raddr);
        end else begin
            m_mis = 0;
            // only an address that was live and accepted moves on
            if (m_valid && fetch_ready) m_pc = m_pc + inc;
            m_valid = 1;
        end
    endfunction

    // scoreboard comparison helper
    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock: advance model from the inputs present at the edge, then compare
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("pc_out",   pc_out,          m_pc);
        check("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
        check("pending",  {31'd0, pending},  {31'd0, m_pend});
        check("misalign", {31'd0, misalign}, {31'd0, m_mis});
    endtask

    // driver
    task automatic drive(input logic p, input logic rdy, input logic rv, input logic [XLEN-1:0] ra,
                         input logic tv, input logic [XLEN-1:0] ta, input logic sh);
        pause = p; fetch_ready = rdy; redirect_valid = rv; redirect_addr = ra;
        trap_valid = tv; trap_vec = ta; step_half = sh;
    endtask

    task automatic idle(input logic rdy);
        drive(0, rdy, 0, '0, 0, '0, 0);
    endtask

    initial begin
        m_pc = START; m_valid = 0; m_pend = 0; m_mis = 0; m_buf = '0; m_btrap = 0;
        rst = 1; idle(1);
        tick(); tick();
        check("reset_pc", pc_out, 32'h100);
        check("reset_valid", {31'd0, pc_valid}, 32'd0);
        check("reset_pending", {31'd0, pending}, 32'd0);

        // free run: BOOT cycle then START, +4, +8
        rst = 0; idle(1);
        tick();
        check("boot_pc", pc_out, 32'h100);
        check("boot_valid", {31'd0, pc_valid}, 32'd1);
        tick(); check("run_plus4", pc_out, 32'h104);
        tick(); check("run_plus8", pc_out, 32'h108);
        repeat (3) tick();

        // backpressure at 0x100
        drive(0, 1, 1, 32'h100, 0, '0, 0); tick();
        idle(0); repeat (3) tick();
        check("bp_hold", pc_out, 32'h100);
        check("bp_valid", {31'd0, pc_valid}, 32'd1);
        idle(1); tick();
        check("bp_advance", pc_out, 32'h104);

        // trap beats redirect
        drive(0, 1, 1, 32'h200, 1, 32'h8000_0000, 0); tick();
        check("prio_trap", pc_out, 32'h8000_0000);

        // paused redirect, replaced by a later redirect
        drive(1, 1, 1, 32'h300, 0, '0, 0); tick();
        check("pend_flag", {31'd0, pending}, 32'd1);
        check("pend_valid", {31'd0, pc_valid}, 32'd0);
        drive(1, 1, 1, 32'h400, 0, '0, 0); tick();
        drive(1, 1, 0, '0, 0, '0, 0); tick();
        idle(1); tick();
        check("resume_pc", pc_out, 32'h400);
        check("resume_pend", {31'd0, pending}, 32'd0);

        // buffered trap survives a later redirect
        drive(1, 1, 0, '0, 1, 32'h500, 0); tick();
        drive(1, 1, 1, 32'h600, 0, '0, 0); tick();
        idle(1); tick();
        check("trap_survives", pc_out, 32'h500);

        // reset while pending discards the buffer
        drive(1, 1, 1, 32'h700, 0, '0, 0); tick();
        rst = 1; idle(1); tick();
        rst = 0; tick(); tick();
        check("rst_discard", pc_out, 32'h104);

        // misaligned redirect
        drive(0, 0, 1, 32'h106, 0, '0, 0); tick();
`ifdef PC_COMPRESSED_EN
        check("mis_pc", pc_out, 32'h106);
        check("mis_pulse", {31'd0, misalign}, 32'd0);
`else
        check("mis_pc", pc_out, 32'h104);
        check("mis_pulse", {31'd0, misalign}, 32'd1);
`endif
        idle(0); tick();
        check("mis_clear", {31'd0, misalign}, 32'd0);

        // wrap-around
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, '0, 0); tick();
        idle(1); tick();
        check("wrap_pc", pc_out, 32'h0);
        check("wrap_mis", {31'd0, misalign}, 32'd0);

`ifdef PC_COMPRESSED_EN
        drive(0, 0, 1, 32'h100, 0, '0, 0); tick();
        drive(0, 1, 0, '0, 0, '0, 1); tick();
        check("half_step", pc_out, 32'h102);
        drive(0, 0, 1, 32'h107, 0, '0, 0); tick();
        check("c_mis_pc", pc_out, 32'h106);
        check("c_mis_pulse", {31'd0, misalign}, 32'd1);
`endif

        // mixed stimulus, model-checked every cycle
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) == 0, $urandom(),
                  $urandom_range(0, 7) == 0, $urandom(),
                  $urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 29) == 0);
            tick();
        end
        rst = 0; idle(1); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
